dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 61 ++++++
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the requester and memory-side signals of the two-port data-memory
// arbiter.
//   core_* / dma_*  : request (req, we, addr, wdata) and response
//                     (gnt, rvalid, rdata) of each requester
//   mem_*           : single-port memory drive (wr_en, addr, dat_in) and the
//                     asynchronous read data returned by the memory (dat_out)
//   busy / owner    : arbiter status (owner 0 = idle, 1 = core, 2 = dma)
// Modports:
//   slave  : the arbiter itself
//   master : the environment, meaning both requesters and the memory
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;

  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dat_in;
  logic [DW-1:0] mem_dat_out;

  logic          busy;
  logic [1:0]    owner;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_wr_en, mem_addr, mem_dat_in,
    input  mem_dat_out,
    output busy, owner
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_wr_en, mem_addr, mem_dat_in,
    output mem_dat_out,
    input  busy, owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between a core and a DMA engine.
// One access is performed per granted cycle. From IDLE a request is granted
// one cycle after it is seen; ties from IDLE go round-robin. While both ports
// request, an owner keeps the memory for at most MAX_BURST consecutive
// accesses; with no competition it keeps it indefinitely.
// Ports:
//   clk   : single clock, all state changes on posedge
//   reset : synchronous active-low reset; also gates grants and writes
//           combinationally while low
//   bus   : dmem_arbiter_if.slave (requesters, memory drive, busy/owner)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int MAX_BURST = 4   // legal range 1..15
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  // Encoding doubles as the owner output value.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    DMA  = 2'd2
  } state_t;

  localparam logic [4:0] BURST_LIM = 5'(MAX_BURST);
  localparam logic [3:0] BURST_SAT = 4'(MAX_BURST);

  state_t        state, state_nxt;
  state_t        last_owner;
  logic [3:0]    cnt, cnt_nxt;      // accesses granted in the current tenure
  logic [4:0]    cnt_inc;
  logic          burst_done;        // the access granted now hits the limit
  logic          core_gnt, dma_gnt;
  logic          core_rvalid, dma_rvalid;
  logic [DW-1:0] core_rdata, dma_rdata;

  // Extra bit so the increment cannot wrap when MAX_BURST is 15.
  assign cnt_inc    = {1'b0, cnt} + 5'd1;
  assign burst_done = (cnt_inc >= BURST_LIM);

  // Next-state and grant logic.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    core_gnt  = 1'b0;
    dma_gnt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.core_req && bus.dma_req)
          state_nxt = (last_owner == DMA) ? CORE : DMA;
        else if (bus.core_req)
          state_nxt = CORE;
        else if (bus.dma_req)
          state_nxt = DMA;
      end
      CORE: begin
        core_gnt = bus.core_req;
        if (!bus.core_req)
          state_nxt = bus.dma_req ? DMA : IDLE;
        else if (bus.dma_req && burst_done)
          state_nxt = DMA;
      end
      DMA: begin
        dma_gnt = bus.dma_req;
        if (!bus.dma_req)
          state_nxt = bus.core_req ? CORE : IDLE;
        else if (bus.core_req && burst_done)
          state_nxt = CORE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset suppresses any access in the cycle it is sampled.
    if (!reset) begin
      core_gnt = 1'b0;
      dma_gnt  = 1'b0;
    end
  end

  // Counter clears whenever the owner changes (including to IDLE) and
  // otherwise saturates at MAX_BURST so a lone owner can stay indefinitely.
  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state)
      cnt_nxt = 4'd0;
    else if (core_gnt || dma_gnt)
      cnt_nxt = burst_done ? BURST_SAT : cnt_inc[3:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      last_owner  <= DMA;          // core wins the first tie after reset
      cnt         <= 4'd0;
      core_rvalid <= 1'b0;
      dma_rvalid  <= 1'b0;
      // NOTE: read-data holding registers are cleared too; they are plain
      // flops, not a memory array, so reset costs nothing here.
      core_rdata  <= '0;
      dma_rdata   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state_nxt != IDLE && state_nxt != state)
        last_owner <= state_nxt;
      core_rvalid <= core_gnt && !bus.core_we;
      dma_rvalid  <= dma_gnt && !bus.dma_we;
      if (core_gnt && !bus.core_we)
        core_rdata <= bus.mem_dat_out;
      if (dma_gnt && !bus.dma_we)
        dma_rdata <= bus.mem_dat_out;
    end
  end

  // Memory drive: follows the granted port, all-zero when nothing is granted.
  always_comb begin
    bus.mem_wr_en  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_dat_in = '0;
    if (core_gnt) begin
      bus.mem_wr_en  = bus.core_we;
      bus.mem_addr   = bus.core_addr;
      bus.mem_dat_in = bus.core_wdata;
    end else if (dma_gnt) begin
      bus.mem_wr_en  = bus.dma_we;
      bus.mem_addr   = bus.dma_addr;
      bus.mem_dat_in = bus.dma_wdata;
    end
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.dma_gnt     = dma_gnt;
  assign bus.core_rvalid = core_rvalid;
  assign bus.dma_rvalid  = dma_rvalid;
  assign bus.core_rdata  = core_rdata;
  assign bus.dma_rdata   = dma_rdata;
  assign bus.busy        = (state != IDLE);
  assign bus.owner       = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Runs two arbiters (MAX_BURST = 4 and MAX_BURST = 1) side by side, each with
// its own behavioural memory, against a cycle-level reference model of the
// arbitration rules. Directed scenarios cover the documented cases; a random
// phase then exercises legal requester behaviour with occasional resets.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  typedef struct packed {
    logic       core_req;
    logic       core_we;
    logic [7:0] core_addr;
    logic [7:0] core_wdata;
    logic       dma_req;
    logic       dma_we;
    logic [7:0] dma_addr;
    logic [7:0] dma_wdata;
  } drv_t;

  typedef struct packed {
    logic       core_gnt;
    logic       dma_gnt;
    logic       core_rvalid;
    logic [7:0] core_rdata;
    logic       dma_rvalid;
    logic [7:0] dma_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_dat_in;
    logic       busy;
    logic [1:0] owner;
  } obs_t;

  logic clk;
  logic rst_n;
  logic mem_clr;
  int   total;
  int   bad;

  drv_t drv   [2];
  obs_t obs_w [2];
  obs_t obs   [2];
  obs_t exp_o [2];

  // Reference model state: 0 idle, 1 core, 2 dma.
  int         m_state [2];
  int         m_last  [2];
  int         m_run   [2];
  bit         m_rv_c  [2];
  bit         m_rv_d  [2];
  logic [7:0] m_rd_c  [2];
  logic [7:0] m_rd_d  [2];
  logic [7:0] m_mem   [2][256];
  int         max_b   [2] = '{4, 1};

  dmem_arbiter_if #(.DW(8), .AW(8)) bus4 ();
  dmem_arbiter_if #(.DW(8), .AW(8)) bus1 ();

  dmem_arbiter #(.DW(8), .AW(8), .MAX_BURST(4)) dut4 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus4.slave)
  );

  dmem_arbiter #(.DW(8), .AW(8), .MAX_BURST(1)) dut1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  // Behavioural memories: contents start at init_val until written.
  logic [7:0]   mem0 [256];
  logic [7:0]   mem1 [256];
  logic [255:0] wf0;
  logic [255:0] wf1;

  assign bus4.mem_dat_out = wf0[bus4.mem_addr] ? mem0[bus4.mem_addr] : init_val(bus4.mem_addr);
  assign bus1.mem_dat_out = wf1[bus1.mem_addr] ? mem1[bus1.mem_addr] : init_val(bus1.mem_addr);

  always @(posedge clk) begin
    if (mem_clr) wf0 <= '0;
    else if (bus4.mem_wr_en) begin
      mem0[bus4.mem_addr] <= bus4.mem_dat_in;
      wf0[bus4.mem_addr]  <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (mem_clr) wf1 <= '0;
    else if (bus1.mem_wr_en) begin
      mem1[bus1.mem_addr] <= bus1.mem_dat_in;
      wf1[bus1.mem_addr]  <= 1'b1;
    end
  end

  function automatic logic [7:0] mem_peek(input int k, input logic [7:0] a);
    if (k == 0) return wf0[a] ? mem0[a] : init_val(a);
    return wf1[a] ? mem1[a] : init_val(a);
  endfunction

  assign bus4.core_req   = drv[0].core_req;
  assign bus4.core_we    = drv[0].core_we;
  assign bus4.core_addr  = drv[0].core_addr;
  assign bus4.core_wdata = drv[0].core_wdata;
  assign bus4.dma_req    = drv[0].dma_req;
  assign bus4.dma_we     = drv[0].dma_we;
  assign bus4.dma_addr   = drv[0].dma_addr;
  assign bus4.dma_wdata  = drv[0].dma_wdata;
  assign bus1.core_req   = drv[1].core_req;
  assign bus1.core_we    = drv[1].core_we;
  assign bus1.core_addr  = drv[1].core_addr;
  assign bus1.core_wdata = drv[1].core_wdata;
  assign bus1.dma_req    = drv[1].dma_req;
  assign bus1.dma_we     = drv[1].dma_we;
  assign bus1.dma_addr   = drv[1].dma_addr;
  assign bus1.dma_wdata  = drv[1].dma_wdata;

  assign obs_w[0] = {bus4.core_gnt, bus4.dma_gnt, bus4.core_rvalid, bus4.core_rdata,
                     bus4.dma_rvalid, bus4.dma_rdata, bus4.mem_wr_en, bus4.mem_addr,
                     bus4.mem_dat_in, bus4.busy, bus4.owner};
  assign obs_w[1] = {bus1.core_gnt, bus1.dma_gnt, bus1.core_rvalid, bus1.core_rdata,
                     bus1.dma_rvalid, bus1.dma_rdata, bus1.mem_wr_en, bus1.mem_addr,
                     bus1.mem_dat_in, bus1.busy, bus1.owner};

  task automatic set_both(input drv_t d);
    drv[0] = d;
    drv[1] = d;
  endtask

  // Called just after a negedge with inputs already applied: samples both
  // DUTs, records the model's expectation for this cycle, advances the model
  // across the coming posedge, and returns at the next negedge.
  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) begin
      drv_t d = drv[k];
      obs_t e = '0;
      bit   cg = rst_n && (m_state[k] == 1) && d.core_req;
      bit   dg = rst_n && (m_state[k] == 2) && d.dma_req;
      int   nxt;
      e.core_gnt    = cg;
      e.dma_gnt     = dg;
      e.core_rvalid = m_rv_c[k];
      e.core_rdata  = m_rd_c[k];
      e.dma_rvalid  = m_rv_d[k];
      e.dma_rdata   = m_rd_d[k];
      if (cg) begin
        e.mem_wr_en = d.core_we; e.mem_addr = d.core_addr; e.mem_dat_in = d.core_wdata;
      end else if (dg) begin
        e.mem_wr_en = d.dma_we; e.mem_addr = d.dma_addr; e.mem_dat_in = d.dma_wdata;
      end
      e.busy  = (m_state[k] != 0);
      e.owner = 2'(m_state[k]);
      exp_o[k] = e;
      obs[k]   = obs_w[k];

      if (!rst_n) begin
        m_state[k] = 0; m_last[k] = 2; m_run[k] = 0;
        m_rv_c[k] = 0; m_rv_d[k] = 0; m_rd_c[k] = '0; m_rd_d[k] = '0;
      end else begin
        m_rv_c[k] = cg && !d.core_we;
        m_rv_d[k] = dg && !d.dma_we;
        if (m_rv_c[k]) m_rd_c[k] = m_mem[k][d.core_addr];
        if (m_rv_d[k]) m_rd_d[k] = m_mem[k][d.dma_addr];
        if (cg && d.core_we) m_mem[k][d.core_addr] = d.core_wdata;
        if (dg && d.dma_we)  m_mem[k][d.dma_addr]  = d.dma_wdata;
        if (cg || dg) m_run[k]++;
        case (m_state[k])
          1: nxt = !d.core_req ? (d.dma_req ? 2 : 0)
                 : ((d.dma_req && m_run[k] >= max_b[k]) ? 2 : 1);
          2: nxt = !d.dma_req ? (d.core_req ? 1 : 0)
                 : ((d.core_req && m_run[k] >= max_b[k]) ? 1 : 2);
          default:
            if (d.core_req && d.dma_req) nxt = (m_last[k] == 2) ? 1 : 2;
            else if (d.core_req)         nxt = 1;
            else if (d.dma_req)          nxt = 2;
            else                         nxt = 0;
        endcase
        if (nxt != m_state[k]) begin
          m_run[k] = 0;
          if (nxt != 0) m_last[k] = nxt;
        end
        m_state[k] = nxt;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drv_t d = '0;
    rst_n = 1'b0;
    d.core_req = 1; d.core_we = 1; d.core_addr = 8'h44; d.core_wdata = 8'h77;
    d.dma_req  = 1; d.dma_we  = 1; d.dma_addr  = 8'h44; d.dma_wdata  = 8'h66;
    set_both(d);
    step();
    mem_clr = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== exp_o[k]) begin
        bad++;
        $display("FAIL reset k=%0d got=%h want=%h", k, obs[k], exp_o[k]);
      end
      total++;
      if ({obs[k].core_gnt, obs[k].dma_gnt, obs[k].mem_wr_en, obs[k].busy, obs[k].owner} !== 6'd0) begin
        bad++;
        $display("FAIL reset_gated k=%0d got=%h want=0", k,
                 {obs[k].core_gnt, obs[k].dma_gnt, obs[k].mem_wr_en, obs[k].busy, obs[k].owner});
      end
      total++;
      if (mem_peek(k, 8'h44) !== init_val(8'h44)) begin
        bad++;
        $display("FAIL reset_nowrite k=%0d got=%h want=%h", k, mem_peek(k, 8'h44), init_val(8'h44));
      end
    end
  endtask

  task automatic test_core_read();
    drv_t d = '0;
    rst_n = 1'b1;
    d.core_req = 1; d.core_addr = 8'h10;
    set_both(d);
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) set_both('0);
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_o[k]) begin
          bad++;
          $display("FAIL core_read c=%0d k=%0d got=%h want=%h", c, k, obs[k], exp_o[k]);
        end
        if (c == 2) begin
          total++;
          if (obs[k].core_gnt !== 1'b1) begin
            bad++;
            $display("FAIL core_read_gnt k=%0d got=%b want=1", k, obs[k].core_gnt);
          end
        end
        if (c == 3) begin
          total++;
          if ({obs[k].core_rvalid, obs[k].core_rdata, obs[k].owner} !== {1'b1, 8'hA5, 2'd1}) begin
            bad++;
            $display("FAIL core_read_data k=%0d got=%h want=%h", k,
                     {obs[k].core_rvalid, obs[k].core_rdata, obs[k].owner}, {1'b1, 8'hA5, 2'd1});
          end
        end
      end
    end
  endtask

  task automatic test_dual_burst();
    drv_t  d = '0;
    string seq [2];
    string want [2];
    want[0] = "CCCCDDDDCCCC";
    want[1] = "CDCDCDCDCDCD";
    rst_n = 1'b0;
    set_both('0);
    step();
    rst_n = 1'b1;
    d.core_req = 1; d.core_addr = 8'h21;
    d.dma_req  = 1; d.dma_addr  = 8'h42;
    set_both(d);
    for (int c = 0; c < 13; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_o[k]) begin
          bad++;
          $display("FAIL dual_burst c=%0d k=%0d got=%h want=%h", c, k, obs[k], exp_o[k]);
        end
        if (c > 0)
          seq[k] = {seq[k], obs[k].core_gnt ? "C" : (obs[k].dma_gnt ? "D" : ".")};
      end
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (seq[k] != want[k]) begin
        bad++;
        $display("FAIL dual_burst_seq k=%0d got=%s want=%s", k, seq[k], want[k]);
      end
    end
  endtask

  task automatic test_dma_write();
    drv_t d = '0;
    int   wr_cnt [2];
    bit   rv_seen [2];
    set_both('0);
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin
        d.dma_req = 1; d.dma_we = 1; d.dma_addr = 8'h80; d.dma_wdata = 8'h3C;
        set_both(d);
      end
      if (c == 4) set_both('0);
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_o[k]) begin
          bad++;
          $display("FAIL dma_write c=%0d k=%0d got=%h want=%h", c, k, obs[k], exp_o[k]);
        end
        if (c >= 2) begin
          wr_cnt[k] += int'(obs[k].mem_wr_en);
          rv_seen[k] |= obs[k].dma_rvalid;
        end
        if (c == 3) begin
          total++;
          if ({obs[k].mem_wr_en, obs[k].mem_addr, obs[k].mem_dat_in} !== {1'b1, 8'h80, 8'h3C}) begin
            bad++;
            $display("FAIL dma_write_bus k=%0d got=%h want=%h", k,
                     {obs[k].mem_wr_en, obs[k].mem_addr, obs[k].mem_dat_in}, {1'b1, 8'h80, 8'h3C});
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (wr_cnt[k] !== 1 || rv_seen[k] !== 1'b0 || mem_peek(k, 8'h80) !== 8'h3C) begin
        bad++;
        $display("FAIL dma_write_once k=%0d wr=%0d rvalid=%b mem=%h want wr=1 rvalid=0 mem=3c",
                 k, wr_cnt[k], rv_seen[k], mem_peek(k, 8'h80));
      end
    end
  endtask

  task automatic test_handover();
    drv_t d = '0;
    // Per-step stimulus {core_req, dma_req} and the MAX_BURST=4 grant string.
    logic [1:0] stim [10] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00};
    string      got  = "";
    string      want = "..CC.D...C.";
    got = ".";
    for (int c = 0; c < 10; c++) begin
      d.core_req = stim[c][1]; d.core_addr = 8'h05;
      d.dma_req  = stim[c][0]; d.dma_addr  = 8'h06;
      set_both(d);
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_o[k]) begin
          bad++;
          $display("FAIL handover c=%0d k=%0d got=%h want=%h", c, k, obs[k], exp_o[k]);
        end
      end
      got = {got, obs[0].core_gnt ? "C" : (obs[0].dma_gnt ? "D" : ".")};
    end
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL handover_seq got=%s want=%s", got, want);
    end
  endtask

  task automatic test_reset_midwrite();
    drv_t d = '0;
    for (int c = 0; c < 6; c++) begin
      d = '0;
      case (c)
        0, 1: begin d.core_req = 1; d.core_addr = 8'h12; end
        2: begin d.core_req = 1; d.core_we = 1; d.core_addr = 8'h33; d.core_wdata = 8'h99; end
        4, 5: begin d.core_req = 1; d.core_addr = 8'h12; end
        default: ;
      endcase
      rst_n = (c != 2);
      set_both(d);
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_o[k]) begin
          bad++;
          $display("FAIL reset_mid c=%0d k=%0d got=%h want=%h", c, k, obs[k], exp_o[k]);
        end
        if (c == 2 || c == 3) begin
          total++;
          if ({obs[k].mem_wr_en, obs[k].core_gnt, obs[k].dma_gnt} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid_gate c=%0d k=%0d got=%b want=000", c, k,
                     {obs[k].mem_wr_en, obs[k].core_gnt, obs[k].dma_gnt});
          end
        end
        if (c == 3) begin
          total++;
          if ({obs[k].core_rvalid, obs[k].dma_rvalid, obs[k].busy, mem_peek(k, 8'h33)} !==
              {3'b000, init_val(8'h33)}) begin
            bad++;
            $display("FAIL reset_mid_after k=%0d got=%h want=%h", k,
                     {obs[k].core_rvalid, obs[k].dma_rvalid, obs[k].busy, mem_peek(k, 8'h33)},
                     {3'b000, init_val(8'h33)});
          end
        end
        if (c == 5) begin
          total++;
          if (obs[k].core_gnt !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_regrant k=%0d got=%b want=1", k, obs[k].core_gnt);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      for (int k = 0; k < 2; k++) begin
        if (!drv[k].core_req || exp_o[k].core_gnt) begin
          drv[k].core_req   = ($urandom_range(0, 3) != 0);
          drv[k].core_we    = 1'($urandom_range(0, 1));
          drv[k].core_addr  = 8'($urandom_range(0, 15));
          drv[k].core_wdata = 8'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          drv[k].core_req = 1'b0;
        end
        if (!drv[k].dma_req || exp_o[k].dma_gnt) begin
          drv[k].dma_req   = ($urandom_range(0, 3) != 0);
          drv[k].dma_we    = 1'($urandom_range(0, 1));
          drv[k].dma_addr  = 8'($urandom_range(0, 15));
          drv[k].dma_wdata = 8'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          drv[k].dma_req = 1'b0;
        end
      end
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_o[k]) begin
          bad++;
          $display("FAIL random c=%0d k=%0d got=%h want=%h", c, k, obs[k], exp_o[k]);
        end
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    mem_clr = 1'b1;
    drv[0]  = '0;
    drv[1]  = '0;
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_last[k] = 2; m_run[k] = 0;
      m_rv_c[k] = 0; m_rv_d[k] = 0; m_rd_c[k] = '0; m_rd_d[k] = '0;
      for (int a = 0; a < 256; a++) m_mem[k][a] = init_val(8'(a));
    end
    @(negedge clk);
    test_reset();
    test_core_read();
    test_dual_burst();
    test_dma_write();
    test_handover();
    test_reset_midwrite();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
